// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter register and single-outstanding instruction-fetch sequencer.
//   It takes the PC source select and the branch, jump and JR operands, computes the
//   next PC when decode retires the current instruction, and fetches one instruction
//   at a time from instruction memory. Each fetched word is presented to decode
//   together with its PC. A JAL also produces the $31 return-address write.
//
//   Optional feature macro: PC_ALIGN_TRAP_EN
//     defined   : a misaligned next PC redirects to TRAP_PC and pulses trap.
//     undefined : next_pc[1:0] is forced to 2'b00 and trap stays 0.
//
//   Ports
//     clk, rst_n                   clock (rising edge), asynchronous active-low reset
//     source                       PC source: 000 PC+4, 001 branch, 010 jump, 011 JR, 100 JAL
//     branch_offset                sign-extended branch immediate, in words
//     jump_index                   J/JAL instruction index field
//     jr_target                    register value for JR
//     stall                        decode not ready; hold the current instruction
//     imem_req / imem_addr         fetch request (held until imem_gnt) and its address (= pc)
//     imem_gnt                     request accepted this cycle
//     imem_rvalid / imem_rdata     returned instruction word
//     instr_valid, instr, instr_pc instruction presented to decode, with its PC
//     pc                           current PC register
//     ra_we / ra_data              one-cycle write of the return address to $31
//     trap                         one-cycle misaligned-target pulse
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] TRAP_PC  = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  source,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc,
    output logic        ra_we,
    output logic [31:0] ra_data,
    output logic        trap
);

    typedef enum logic [1:0] {S_RST, S_REQ, S_WAIT, S_HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] ra_data_q, ra_data_d;
    logic        instr_valid_q, instr_valid_d;
    logic        ra_we_q, ra_we_d;
    logic        trap_q, trap_d;

    logic [31:0] p4;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        misaligned;

    // Target selection. Sources 101..111 fall through to PC+4.
    always_comb begin
        p4 = instr_pc_q + 32'd4;
        case (source)
            3'b001:         target = p4 + (branch_offset << 2);
            3'b010, 3'b100: target = {p4[31:28], jump_index, 2'b00};
            3'b011:         target = jr_target;
            default:        target = p4;
        endcase
    end

`ifdef PC_ALIGN_TRAP_EN
    always_comb begin
        misaligned = |target[1:0];
        next_pc    = misaligned ? TRAP_PC : target;
    end
`else
    always_comb begin
        misaligned = 1'b0;
        next_pc    = target & ~32'd3;
    end
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        ra_data_d     = ra_data_q;
        ra_we_d       = 1'b0;
        trap_d        = 1'b0;
        case (state_q)
            S_RST: state_d = S_REQ;
            S_REQ: begin
                if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                // rvalid is only meaningful here; elsewhere it is a stale or late response.
                if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                // Retire: operands are sampled only in this cycle.
                if (!stall) begin
                    pc_d          = next_pc;
                    instr_valid_d = 1'b0;
                    trap_d        = misaligned;
                    state_d       = S_REQ;
                    if (source == 3'b100) begin
                        ra_we_d   = 1'b1;
                        ra_data_d = p4;
                    end
                end
            end
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RST;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            ra_data_q     <= '0;
            ra_we_q       <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            ra_data_q     <= ra_data_d;
            ra_we_q       <= ra_we_d;
            trap_q        <= trap_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign ra_we       = ra_we_q;
    assign ra_data     = ra_data_q;
    assign trap        = trap_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: plays instruction memory with random grant and
// response delays plus stray responses, and tracks the expected PC stream with a
// transaction-level model of the next-PC rules.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] TRAP_PC  = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  source;
    logic [31:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic        ra_we;
    logic [31:0] ra_data;
    logic        trap;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc;

    pc_fetch_unit #(.RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC)) dut (
        .clk(clk), .rst_n(rst_n), .source(source), .branch_offset(branch_offset),
        .jump_index(jump_index), .jr_target(jr_target), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .pc(pc), .ra_we(ra_we), .ra_data(ra_data),
        .trap(trap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rules, expressed arithmetically.
    task automatic model_next(input logic [31:0] ipc, input logic [2:0] s, input logic [31:0] off,
                              input logic [25:0] idx, input logic [31:0] jr,
                              output logic [31:0] npc, output logic t, output logic we,
                              output logic [31:0] ra);
        logic [31:0] p4, tgt;
        p4 = ipc + 32'd4;
        case (s)
            3'd1:       tgt = p4 + off * 32'd4;
            3'd2, 3'd4: tgt = (p4 & 32'hF000_0000) + 32'(idx) * 32'd4;
            3'd3:       tgt = jr;
            default:    tgt = p4;
        endcase
        we = (s == 3'd4);
        ra = p4;
`ifdef PC_ALIGN_TRAP_EN
        t   = (tgt % 4) != 0;
        npc = t ? TRAP_PC : tgt;
`else
        t   = 1'b0;
        npc = tgt - (tgt % 4);
`endif
    endtask

    // One full fetch/hold/retire transaction. Negative delay arguments pick random values.
    task automatic fetch_one(input int gdly, input int rdly, input int hold_n, input bit rnd,
                             input logic [2:0] s, input logic [31:0] off,
                             input logic [25:0] idx, input logic [31:0] jr);
        logic [31:0] word, npc, ra, rv;
        logic        t, we;
        int          n, g, r, h;
        n = 0;
        while (!imem_req && n < 8) begin
            tick();
            n++;
        end
        check_eq("req_up", imem_req, 1);
        check_eq("fetch_addr", imem_addr, exp_pc);
        check_eq("pc_at_req", pc, exp_pc);
        g = (gdly < 0) ? int'($urandom_range(0, 2)) : gdly;
        r = (rdly < 0) ? int'($urandom_range(0, 2)) : rdly;
        h = (hold_n < 0) ? int'($urandom_range(0, 3)) : hold_n;
        for (int i = 0; i < g; i++) begin
            imem_gnt    = 1'b0;
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            tick();
            check_eq("req_held", imem_req, 1);
            check_eq("no_valid_in_req", instr_valid, 0);
        end
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        tick();
        imem_gnt = 1'b0;
        check_eq("req_drop", imem_req, 0);
        for (int i = 0; i < r; i++) begin
            tick();
            check_eq("no_valid_in_wait", instr_valid, 0);
        end
        word        = $urandom;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        stall       = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        check_eq("instr_valid", instr_valid, 1);
        check_eq("instr", instr, word);
        check_eq("instr_pc", instr_pc, exp_pc);
        for (int i = 0; i < h; i++) begin
            stall       = 1'b1;
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            source      = 3'($urandom);
            tick();
            check_eq("hold_valid", instr_valid, 1);
            check_eq("hold_instr", instr, word);
            check_eq("hold_instr_pc", instr_pc, exp_pc);
            check_eq("hold_pc", pc, exp_pc);
            check_eq("hold_no_req", imem_req, 0);
        end
        imem_rvalid = 1'b0;
        if (rnd) begin
            s   = 3'($urandom);
            off = (($urandom % 2) == 0) ? 32'($signed($urandom_range(0, 64)) - 32) : $urandom;
            idx = 26'($urandom);
            rv  = $urandom;
            jr  = (($urandom % 4) == 0) ? rv : (rv & 32'hFFFF_FFFC);
        end
        source        = s;
        branch_offset = off;
        jump_index    = idx;
        jr_target     = jr;
        stall         = 1'b0;
        tick();
        stall = 1'b1;
        model_next(exp_pc, s, off, idx, jr, npc, t, we, ra);
        check_eq("retire_valid", instr_valid, 0);
        check_eq("next_pc", pc, npc);
        check_eq("next_req", imem_req, 1);
        check_eq("next_addr", imem_addr, npc);
        check_eq("ra_we", ra_we, 32'(we));
        if (we) check_eq("ra_data", ra_data, ra);
        check_eq("trap", trap, 32'(t));
        exp_pc = npc;
        imem_gnt = 1'b0;
        tick();
        check_eq("ra_we_pulse", ra_we, 0);
        check_eq("trap_pulse", trap, 0);
        check_eq("req_still", imem_req, 1);
    endtask

    // Reset while waiting for a response; the late response must be dropped.
    task automatic reset_mid_wait();
        int n;
        n = 0;
        while (!imem_req && n < 8) begin
            tick();
            n++;
        end
        check_eq("rst_req_up", imem_req, 1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_pc", pc, RESET_PC);
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_instr_pc", instr_pc, 0);
        tick();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        tick();
        imem_rvalid = 1'b0;
        check_eq("late_rvalid_dropped", instr_valid, 0);
        check_eq("refetch_addr", imem_addr, RESET_PC);
        exp_pc = RESET_PC;
    endtask

    initial begin
        rst_n         = 1'b0;
        source        = 3'd0;
        branch_offset = '0;
        jump_index    = '0;
        jr_target     = '0;
        stall         = 1'b1;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_pc", pc, RESET_PC);
        check_eq("reset_req", imem_req, 0);
        check_eq("reset_valid", instr_valid, 0);
        check_eq("reset_instr", instr, 0);
        check_eq("reset_instr_pc", instr_pc, 0);
        check_eq("reset_ra_we", ra_we, 0);
        check_eq("reset_ra_data", ra_data, 0);
        check_eq("reset_trap", trap, 0);
        rst_n  = 1'b1;
        exp_pc = RESET_PC;

        fetch_one(0, 0, 0, 1'b0, 3'd0, 32'd0, 26'd0, 32'd0);
        fetch_one(-1, -1, -1, 1'b0, 3'd0, 32'd0, 26'd0, 32'd0);
        fetch_one(-1, -1, -1, 1'b0, 3'd1, 32'd3, 26'd0, 32'd0);
        check_eq("branch_target", exp_pc, 32'h0040_0018);
        fetch_one(-1, -1, -1, 1'b0, 3'd3, 32'd0, 26'd0, 32'h0040_0010);
        fetch_one(-1, -1, 5, 1'b0, 3'd4, 32'd0, 26'h010_0004, 32'd0);
        fetch_one(-1, -1, -1, 1'b0, 3'd3, 32'd0, 26'd0, 32'h0040_0102);
        fetch_one(-1, -1, -1, 1'b0, 3'd3, 32'd0, 26'd0, 32'hFFFF_FFFC);
        fetch_one(-1, -1, -1, 1'b0, 3'd0, 32'd0, 26'd0, 32'd0);
        check_eq("wrap_pc", exp_pc, 32'h0000_0000);
        fetch_one(-1, -1, -1, 1'b0, 3'd3, 32'd0, 26'd0, RESET_PC);
        reset_mid_wait();
        fetch_one(-1, -1, -1, 1'b0, 3'd0, 32'd0, 26'd0, 32'd0);
        for (int k = 0; k < 200; k++)
            fetch_one(-1, -1, -1, 1'b1, 3'd0, 32'd0, 26'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
